// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
//
// Execute-stage iterative multiply/divide unit with architectural HI/LO.
// MULT/MULTU use shift-add and DIV/DIVU use a restoring divide, producing
// one bit per cycle. MFHI/MFLO/MTHI/MTLO are also served here. While an
// operation is in flight, `stall` holds IF/ID/EX if the instruction in EX
// depends on the unit.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   start    in   EX instruction is mult/div (accepted only in IDLE)
//   op       in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   busA     in   rs operand (multiplicand / dividend, MTHI/MTLO data)
//   busB     in   rt operand (multiplier / divisor)
//   mfhi     in   EX instruction reads HI
//   mflo     in   EX instruction reads LO
//   mthi     in   EX instruction writes HI from busA
//   mtlo     in   EX instruction writes LO from busA
//   busy     out  operation in flight
//   stall    out  hold pipeline and EX register
//   result   out  HI, LO or 0 for the execute-result mux
//   hi       out  architectural HI
//   lo       out  architectural LO
// ---------------------------------------------------------------------------
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32   // must equal WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic             mfhi,
    input  logic             mflo,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;       // multiplicand / divisor during RUN
    logic [2*WIDTH-1:0]     acc_q, acc_d;   // product, or {remainder, quotient}
    logic                   neg_res_q, neg_res_d;
    logic                   neg_rem_q, neg_rem_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;

    logic                   is_div;
    logic                   is_signed;
    logic                   sign_a, sign_b;
    logic [WIDTH-1:0]       abs_a, abs_b;
    logic [WIDTH:0]         mul_sum;
    logic [WIDTH:0]         div_shift;
    logic [WIDTH:0]         div_diff;
    logic                   div_ge;
    logic [WIDTH-1:0]       div_rem;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       quo_fix, rem_fix;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_PREP;
            S_PREP: state_d = S_RUN;
            S_RUN:  if (cnt_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy   = (state_q != S_IDLE);
        stall  = busy & (start | mfhi | mflo | mthi | mtlo);
        result = mfhi ? hi_q : (mflo ? lo_q : '0);
        hi     = hi_q;
        lo     = lo_q;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_comb begin
        sign_a = is_signed & a_q[WIDTH-1];
        sign_b = is_signed & b_q[WIDTH-1];
        abs_a  = sign_a ? -a_q : a_q;
        abs_b  = sign_b ? -b_q : b_q;

        // Shift-add: add the multiplicand into the upper half when the
        // current multiplier bit (acc[0]) is set, then shift right.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                  (acc_q[0] ? {1'b0, b_q} : '0);

        // Restoring divide: shift the next dividend bit into the partial
        // remainder and subtract the divisor if it fits. The partial
        // remainder stays below the divisor, so WIDTH+1 bits suffice; with
        // a zero divisor every step "fits", giving all-ones quotient and
        // the dividend as remainder.
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d = op;
                    a_d  = busA;
                    b_d  = busB;
                end else begin
                    // start wins over MTHI/MTLO; stall is 0 here by construction
                    if (mthi) hi_d = busA;
                    if (mtlo) lo_d = busA;
                end
            end
            S_PREP: begin
                neg_res_d = sign_a ^ sign_b;
                neg_rem_d = sign_a;
                cnt_d     = CW'(ITER - 1);
                if (is_div) begin
                    acc_d = {{WIDTH{1'b0}}, abs_a};
                    b_d   = abs_b;
                end else begin
                    acc_d = {{WIDTH{1'b0}}, abs_b};
                    b_d   = abs_a;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (is_div) begin
                    acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
            end
            S_FIX: begin
                if (is_div) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_unit
//
// Scoreboard bench for ex_muldiv_unit: each accepted mult/div pushes its
// expected {HI,LO}; the entry is popped and compared when busy drops.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] busA, busB;
    logic        mfhi, mflo, mthi, mtlo;
    logic        busy, stall;
    logic [31:0] result, hi, lo;

    logic [63:0] sb_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;

    ex_muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .busA   (busA),
        .busB   (busB),
        .mfhi   (mfhi),
        .mflo   (mflo),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .busy   (busy),
        .stall  (stall),
        .result (result),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference {HI,LO} for one operation.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            2'b00: begin
                p = sa * sb;
                return p;
            end
            2'b01: return {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 32'd0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one start for a single edge and record its expected result.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
        start = 1'b1;
        op    = o;
        busA  = a;
        busB  = b;
        sb_q.push_back(exp);
        step();
        start = 1'b0;
        chk("busy_after_start", {63'b0, busy}, 64'd1);
    endtask

    // Wait (bounded) for completion, check latency and the popped result.
    task automatic retire(input string tag);
        int          cyc;
        logic [63:0] exp;
        cyc = 0;
        while (busy && cyc < 100) begin
            step();
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd34);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
        chk({tag, "_hilo"}, {hi, lo}, exp);
    endtask

    initial begin
        logic [63:0] exp;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          cyc;

        reset = 1'b1; start = 1'b0; op = 2'b00; busA = '0; busB = '0;
        mfhi = 1'b0; mflo = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        step();
        step();
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        step();
        chk("idle_stall", {63'b0, stall}, 64'd0);
        chk("idle_result", {32'b0, result}, 64'd0);

        // MULTU max x max
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        retire("multu_max");

        // MULT -3 x 7, then MFLO
        issue(2'b00, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        retire("mult_neg");
        mflo = 1'b1;
        #1;
        chk("mflo_result", {32'b0, result}, 64'h0000_0000_FFFF_FFEB);
        chk("mflo_stall", {63'b0, stall}, 64'd0);
        mflo = 1'b0;
        step();

        // Divides incl. divide by zero and overflow
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        retire("div_neg");
        issue(2'b11, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF);
        retire("divu_zero");
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        retire("div_ovf");
        issue(2'b10, 32'hFFFF_FF9C, 32'd0, model(2'b10, 32'hFFFF_FF9C, 32'd0));
        retire("div_zero_neg");

        // Independent instruction proceeds; dependent MFHI stalls
        exp = model(2'b00, 32'h1234_5678, 32'hFFFF_FFFB);
        issue(2'b00, 32'h1234_5678, 32'hFFFF_FFFB, exp);
        step();
        step();
        chk("indep_stall", {63'b0, stall}, 64'd0);
        chk("indep_busy", {63'b0, busy}, 64'd1);
        step(); step(); step();
        mfhi = 1'b1;
        #1;
        chk("mfhi_stall", {63'b0, stall}, 64'd1);
        cyc = 5;
        while (stall && cyc < 100) begin
            step();
            cyc++;
        end
        chk("mfhi_release", 64'(cyc), 64'd34);
        chk("mfhi_result", {32'b0, result}, {32'b0, exp[63:32]});
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
        chk("mfhi_hilo", {hi, lo}, exp);
        mfhi = 1'b0;
        step();

        // MTHI / MTLO in IDLE
        mthi = 1'b1; busA = 32'h0000_1234;
        step();
        mthi = 1'b0;
        chk("mthi", {32'b0, hi}, 64'h1234);
        mtlo = 1'b1; busA = 32'hCAFE_F00D;
        step();
        mtlo = 1'b0;
        chk("mtlo", {hi, lo}, 64'h0000_1234_CAFE_F00D);

        // Back-to-back start while busy
        issue(2'b01, 32'd3, 32'd5, 64'd15);
        step(); step(); step();
        start = 1'b1; op = 2'b11; busA = 32'd100; busB = 32'd7;
        #1;
        chk("b2b_stall", {63'b0, stall}, 64'd1);
        cyc = 3;
        while (stall && cyc < 100) begin
            step();
            cyc++;
        end
        chk("b2b_release", 64'(cyc), 64'd34);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
        chk("b2b_first_hilo", {hi, lo}, exp);
        sb_q.push_back({32'd2, 32'd14});
        step();
        start = 1'b0;
        chk("b2b_second_busy", {63'b0, busy}, 64'd1);
        retire("b2b_second");

        // Asynchronous reset during RUN
        issue(2'b00, 32'd9, 32'd9, 64'd81);
        for (int i = 0; i < 11; i++) step();
        chk("pre_rst_busy", {63'b0, busy}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        #1;
        reset = 1'b0;
        void'(sb_q.pop_front());
        step();
        issue(2'b00, 32'hFFFF_FFF0, 32'h0000_0100, 64'hFFFF_FFFF_FFFF_F000);
        retire("post_rst");

        // Random operations against the model
        for (int i = 0; i < 10; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 1) ? 32'($urandom_range(1, 50)) : $urandom;
            if (i == 4) rb = 32'd0;
            if (i == 6) rb = 32'hFFFF_FFFF;
            issue(ro, ra, rb, model(ro, ra, rb));
            retire("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Execute-stage multiply/divide unit that sits directly upstream of the memory stage.
- Executes MULT/MULTU/DIV/DIVU iteratively into architectural HI/LO registers and serves MFHI/MFLO/MTHI/MTLO.
- Its `result` is muxed into the execute result that feeds the memory stage's ExecResult input.
- Drives `stall` to freeze IF/ID/EX while an operation is in flight and a dependent instruction is waiting.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- ITER, 32, iteration cycles in RUN; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  EX instruction is a mult/div; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- busA  input  WIDTH  rs operand (multiplicand / dividend)
- busB  input  WIDTH  rt operand (multiplier / divisor)
- mfhi  input  1  EX instruction reads HI
- mflo  input  1  EX instruction reads LO
- mthi  input  1  EX instruction writes HI from busA
- mtlo  input  1  EX instruction writes LO from busA
- busy  output  1  operation in flight
- stall  output  1  hold pipeline and EX register
- result  output  WIDTH  HI, LO or 0 for the execute-result mux
- hi  output  WIDTH  architectural HI
- lo  output  WIDTH  architectural LO

Behaviour:
- Clocking and reset: one clock `clk`. `reset` is asynchronous and active-high. While asserted: state=IDLE, hi=0, lo=0, all internal accumulators/counters=0, busy=0.
- FSM states: IDLE, PREP, RUN, FIX.
- IDLE: on `start`=1, latch op, busA, busB → PREP.
  - start has priority over mthi/mtlo in the same cycle (decoder never asserts both).
- PREP (1 cycle):
  - For signed ops (MULT, DIV), form absolute values of both operands; record result sign = signA^signB and remainder sign = signA.
  - Unsigned ops pass operands through unchanged.
  - Load counter=ITER-1 → RUN.
- RUN (ITER cycles):
  - MULT/MULTU: shift-add, 1 bit per cycle, into a 2*WIDTH product.
  - DIV/DIVU: restoring divide, 1 quotient bit per cycle.
  - Counter decrements; at counter=0 → FIX.
- FIX (1 cycle):
  - Apply sign correction.
  - MULT: negate the 64-bit product if result sign = 1. DIV: negate the quotient if result sign = 1; negate the remainder if remainder sign = 1.
  - Write HI/LO: mult → HI=product[63:32], LO=product[31:0]; div → LO=quotient, HI=remainder.
  - → IDLE.
- Latency: start sampled at edge 0; HI/LO updated at edge ITER+2 (34); busy=1 from after edge 0 until edge 34 (busy=0 in cycle 34).
- busy: registered, equals (state != IDLE).
- stall: combinational, equals busy & (start | mfhi | mflo | mthi | mtlo).
  - An independent instruction proceeds while busy (no stall).
  - A start while busy is not accepted; the instruction is held by stall until IDLE, then accepted.
- result: combinational. mfhi ? hi : (mflo ? lo : 0). Reflects the current hi/lo; valid only when stall=0.
- MTHI/MTLO:
  - In IDLE with stall=0, hi (or lo) ← busA at the next edge.
  - While busy they stall and write after completion, so an in-flight op's FIX write is never overtaken.
- Divide by zero (busB=0): no trap. Restoring algorithm result stands: DIVU → LO=0xFFFFFFFF, HI=busA; DIV → sign correction applied to that result.
- Overflow 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0.
- Reset mid-operation: aborts immediately; HI/LO=0; no partial write.

Test Plan:
- MULTU 0xFFFFFFFF×0xFFFFFFFF → after 34 cycles HI=0xFFFFFFFE, LO=0x00000001; busy high exactly 34 cycles.
- MULT 0xFFFFFFFD(-3)×7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MFLO → result=0xFFFFFFEB, stall=0.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/0 → LO=0xFFFFFFFF, HI=100. DIV 0x80000000/-1 → LO=0x80000000, HI=0.
- MULT started, MFHI issued 5 cycles later → stall=1 until cycle 34. On release, result = new HI. An unrelated ADD at cycle 2 → stall=0.
- MTHI 0x1234 in IDLE → hi=0x1234 next edge. Back-to-back start while busy → second op begins only after first HI/LO write.
- Assert reset at RUN cycle 10 → busy=0, hi=lo=0 immediately (asynchronous); next start completes normally.
